// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an N-digit common-anode
// seven-segment display. Each digit gets an optional all-off gap and then a
// SHOW slot. The displayed value is double-buffered: a load goes into a
// shadow copy, and that copy moves to the display only at a frame boundary.
// Optional feature macro: SEG_SCAN_DIM_EN adds a 3-bit live brightness input
// that shortens the lit part of each SHOW slot.
// All of an/seg/dp/frame_done are registered. They are decoded from the
// next-state values, so they change on the same edge that enters a state.

module sevenSegDec (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Active-low segment patterns, seg[6]=a .. seg[0]=g.
  always_comb begin
    case (hex)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      default: seg = 7'h38;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 25_000,
  parameter int GAP_CYCLES   = 100,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0]              bright,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done,
  output logic                    dbg_state
);

  typedef enum logic {ST_GAP = 1'b0, ST_SHOW = 1'b1} state_t;

  localparam int MAX_LEN = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int BLK_W   = $clog2(BLINK_CYCLES + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
  localparam state_t RESET_ST = (GAP_CYCLES == 0) ? ST_SHOW : ST_GAP;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        slot_q, slot_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic                    pending_q, pending_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_ph_q, blink_ph_d;
  logic                    frame_d, lit_d;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d, dec_seg;
  logic                    dp_d;
  logic [3:0]              nib_d;
`ifdef SEG_SCAN_DIM_EN
  logic [31:0]             dim_lim;
`endif

  assign dbg_state = state_q;

  sevenSegDec u_dec (.hex(nib_d), .seg(dec_seg));

  // Next-state: scan sequencing, shadow/commit, blink timer and output decode.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q + 1'b1;
    idx_d       = idx_q;
    frame_d     = 1'b0;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;

    case (state_q)
      ST_GAP: begin
        if (slot_q == GAP_LAST) begin
          state_d = ST_SHOW;
          slot_d  = '0;
        end
      end
      default: begin
        if (slot_q == DIG_LAST) begin
          slot_d  = '0;
          state_d = (GAP_CYCLES == 0) ? ST_SHOW : ST_GAP;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            frame_d = 1'b1;
            if (pending_q) begin
              disp_d    = shadow_q;
              disp_dp_d = shadow_dp_q;
              pending_d = 1'b0;
            end
          end
        end
      end
    endcase

    // A load on the commit edge lands after the commit, so it stays pending.
    if (load) begin
      shadow_d    = value;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end

    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_ph_d  = blink_ph_q;
    end

    // The digit is lit only if it is in SHOW and no blanking source applies.
    nib_d = 4'(disp_d >> {idx_d, 2'b00});
    lit_d = (state_d == ST_SHOW);
    if (lz_blank && (idx_d != '0) && ((disp_d >> {idx_d, 2'b00}) == '0)) lit_d = 1'b0;
    if (blink_ph_d && blink_mask[idx_d]) lit_d = 1'b0;
`ifdef SEG_SCAN_DIM_EN
    dim_lim = ((32'(bright) + 32'd1) * 32'(DIGIT_CYCLES)) >> 3;
    if (32'(slot_d) >= dim_lim) lit_d = 1'b0;
`endif

    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit_d) begin
      an_d[idx_d] = 1'b0;
      seg_d       = dec_seg;
      dp_d        = ~disp_dp_d[idx_d];
    end
  end

  // State and registered outputs; reset aborts the scan and drops any pending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_ST;
      slot_q      <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pending_q   <= pending_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_done  <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (N=4, DIGIT=8, GAP=2, BLINK=64; 40-cycle frame).
// The reference model derives the scan position from the number of clock
// edges since reset with plain arithmetic. It tracks the shadow/display
// buffers and predicts an/seg/dp/frame_done for every cycle. Hand-computed
// literal checks pin the model at known points in the scan.

module tb_seg_scan_ctrl;
  localparam int N = 4, D = 8, G = 2, B = 64;
  localparam int SLOT = D + G, FRAME = N * SLOT;
  localparam logic [6:0] SEG_TAB [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                          7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0;
  logic load = 1'b0;
  logic lz_blank = 1'b0;
  logic [3:0] blink_mask = '0;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0] bright = 3'd7;
`endif
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, frame_done, dbg_state;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  int m_t = 0;
  logic [15:0] m_shadow = '0, m_disp = '0;
  logic [3:0] m_sdp = '0, m_ddp = '0;
  bit m_pend = 1'b0;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic e_dp = 1'b1, e_fd = 1'b0;
  int pos, dig, off, lim;
  bit lit;
  logic [3:0] nib;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_CYCLES(D), .GAP_CYCLES(G), .BLINK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
    .lz_blank(lz_blank), .blink_mask(blink_mask),
`ifdef SEG_SCAN_DIM_EN
    .bright(bright),
`endif
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Reference model: advance one edge and predict what the outputs must show.
  always @(posedge clk) begin
    if (reset) begin
      m_t = 0; m_shadow = '0; m_sdp = '0; m_pend = 1'b0; m_disp = '0; m_ddp = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      m_t = m_t + 1;
      e_fd = ((m_t % FRAME) == 0);
      if (e_fd && m_pend) begin
        m_disp = m_shadow; m_ddp = m_sdp; m_pend = 1'b0;
      end
      if (load) begin
        m_shadow = value; m_sdp = dp_in; m_pend = 1'b1;
      end
      pos = m_t % FRAME;
      dig = pos / SLOT;
      off = pos % SLOT;
      lit = (off >= G);
      if (lz_blank && dig > 0 && (m_disp >> (4 * dig)) == 16'h0) lit = 1'b0;
      if (((m_t / B) % 2) == 1 && blink_mask[dig]) lit = 1'b0;
`ifdef SEG_SCAN_DIM_EN
      lim = ((int'(bright) + 1) * D) / 8;
      if ((off - G) >= lim) lit = 1'b0;
`else
      lim = D;
`endif
      nib = 4'(m_disp >> (4 * dig));
      e_an = lit ? 4'(~(4'b0001 << dig)) : 4'hF;
      e_seg = lit ? SEG_TAB[nib] : 7'h7F;
      e_dp = lit ? ~m_ddp[dig] : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  // Scoreboard compare: every cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  // Driver tasks
  task automatic goto_t(input int target);
    int guard = 0;
    while (m_t != target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (m_t != target) begin
      total++; bad++;
      $display("FAIL goto_timeout: got t=%0d expected t=%0d", m_t, target);
    end
  endtask

  task automatic goto_mod(input int r);
    int guard = 0;
    while ((m_t % FRAME) != r && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if ((m_t % FRAME) != r) begin
      total++; bad++;
      $display("FAIL gotomod_timeout: got pos=%0d expected pos=%0d", m_t % FRAME, r);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    reset = 1'b0;

    // Plain scan of 0000 and a load captured mid-frame.
    goto_t(1);  check("gap0_an", 32'(an), 32'hF);
    goto_t(2);  check("show0_an", 32'(an), 32'hE); check("show0_seg", 32'(seg), 32'h01);
    goto_t(4);  pulse_load(16'h1234, 4'b0100);
    goto_t(12); check("show1_an", 32'(an), 32'hD);
    goto_t(32); check("f1_d3_an", 32'(an), 32'h7); check("f1_d3_seg", 32'(seg), 32'h01);
    goto_t(40); check("fd_40", 32'(frame_done), 32'h1);
    goto_t(41); check("fd_41", 32'(frame_done), 32'h0);
    goto_t(42); check("f2_d0_seg", 32'(seg), 32'h4C); check("f2_d0_dp", 32'(dp), 32'h1);
    goto_t(62); check("f2_d2_an", 32'(an), 32'hB); check("f2_d2_dp", 32'(dp), 32'h0);
    check("f2_d2_seg", 32'(seg), 32'h12);
    goto_t(72); check("f2_d3_seg", 32'(seg), 32'h4F);

    // Overwritten shadow, and a load on the commit edge.
    goto_t(89);  pulse_load(16'hAAAA, 4'h0);
    goto_t(99);  pulse_load(16'h5555, 4'h0);
    goto_t(122); check("ovw_seg", 32'(seg), 32'h24);
    goto_t(149); pulse_load(16'h1111, 4'h0);
    goto_t(159); pulse_load(16'h2222, 4'h0);
    goto_t(162); check("edge_old_seg", 32'(seg), 32'h4F);
    goto_t(202); check("edge_new_seg", 32'(seg), 32'h12);

    // Leading-zero blanking.
    goto_t(204); lz_blank = 1'b1; pulse_load(16'h0070, 4'h0);
    goto_t(245); check("lz_d0_an", 32'(an), 32'hE); check("lz_d0_seg", 32'(seg), 32'h01);
    goto_t(255); check("lz_d1_an", 32'(an), 32'hD); check("lz_d1_seg", 32'(seg), 32'h0F);
    goto_t(265); check("lz_d2_an", 32'(an), 32'hF);
    goto_t(275); check("lz_d3_an", 32'(an), 32'hF); check("lz_d3_seg", 32'(seg), 32'h7F);
    goto_t(284); pulse_load(16'h0000, 4'h0);
    goto_t(325); check("lz0_d0_an", 32'(an), 32'hE); check("lz0_d0_seg", 32'(seg), 32'h01);
    goto_t(335); check("lz0_d1_an", 32'(an), 32'hF);
    goto_t(355); check("lz0_d3_an", 32'(an), 32'hF);

    // Blink on digit 0.
    goto_t(364); lz_blank = 1'b0; pulse_load(16'h4321, 4'h0);
    goto_t(399); blink_mask = 4'b0001;
    goto_t(402); check("blk_on_an", 32'(an), 32'hE); check("blk_on_seg", 32'(seg), 32'h4F);
    goto_t(445); check("blk_p0_an", 32'(an), 32'hE);
    goto_t(449); check("blk_p1_an", 32'(an), 32'hF);
    goto_t(482); check("blk_off_an", 32'(an), 32'hF);
    goto_t(492); check("blk_d1_an", 32'(an), 32'hD); check("blk_d1_seg", 32'(seg), 32'h12);
    goto_t(522); check("blk_back_an", 32'(an), 32'hE);

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) lz_blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) blink_mask = 4'($urandom_range(0, 15));
`ifdef SEG_SCAN_DIM_EN
      if ($urandom_range(0, 99) == 0) bright = 3'($urandom_range(0, 7));
`endif
      reset = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    reset = 1'b0; load = 1'b0; lz_blank = 1'b0; blink_mask = '0;
`ifdef SEG_SCAN_DIM_EN
    bright = 3'd7;
`endif

    // Reset mid-SHOW of digit 2 with a load pending.
    goto_mod(20); pulse_load(16'hFFFF, 4'hF);
    goto_mod(24); reset = 1'b1;
    @(negedge clk);
    check("rst_mid_an", 32'(an), 32'hF); check("rst_mid_seg", 32'(seg), 32'h7F);
    check("rst_mid_dp", 32'(dp), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    goto_t(2);  check("rst_rs_an", 32'(an), 32'hE); check("rst_rs_seg", 32'(seg), 32'h01);
    goto_t(42); check("rst_drop_seg", 32'(seg), 32'h01);
    goto_t(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
